irq_controller: RTL and testbench

- Parametrised multi-output interrupt controller for the PWM subsystem.
- Samples N_SRC interrupt sources. Each source is qualified per source as edge or level.
- Each output channel has its own mask row, a sticky pending register and an ack handshake.
- Each output reports the lowest-numbered pending source ID. It sits between the PWM/timer event lines and the PS interrupt inputs / AXI register file.

---
 rtl/irq_controller_pkg.sv | 26 ++
 rtl/irq_channel.sv | 86 ++++++++
 rtl/irq_controller.sv | 55 +++++
 tb/tb_irq_controller.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_controller_pkg.sv
// Shared types and helpers for the PWM-subsystem interrupt controller.
// The default source count follows the PWM channel width when the build defines it.
`ifndef PWM_WIDTH
`define PWM_WIDTH 8
`endif

package irq_controller_pkg;

  typedef enum logic {IRQ_IDLE, IRQ_ACTIVE} irq_state_t;

  localparam int IRQ_N_SRC_DEFAULT = `PWM_WIDTH;

  // Widest source vector the priority encoder accepts; channels zero-extend into it.
  localparam int IRQ_MAX_SRC = 64;

  // Priority encoder: index of the lowest set bit, 0 when the vector is empty.
  function automatic int lowest_set(input logic [IRQ_MAX_SRC-1:0] vec);
    int idx;
    idx = 0;
    for (int i = IRQ_MAX_SRC - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_channel.sv
// One output channel: sticky pending bits, edge-overflow flag, priority encode
// and the IDLE/ACTIVE request/acknowledge FSM.
module irq_channel
  import irq_controller_pkg::*;
#(
  parameter  int N_SRC = IRQ_N_SRC_DEFAULT,
  localparam int ID_W  = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] evt_i,
  input  logic [N_SRC-1:0] edge_mode_i,
  input  logic [N_SRC-1:0] mask_i,
  input  logic             int_ack_i,
  input  logic             ovf_clr_i,
  output logic             irq_out_o,
  output logic [ID_W-1:0]  irq_id_o,
  output logic [N_SRC-1:0] pending_o,
  output logic             overflow_o
);

  irq_state_t             state_q;
  logic                   irq_out_q;
  logic [ID_W-1:0]        id_q;
  logic [ID_W-1:0]        lowest_id;
  logic [N_SRC-1:0]       pending_q, pending_d;
  logic [N_SRC-1:0]       set_vec, clr_vec;
  logic                   overflow_q, overflow_d;
  logic [IRQ_MAX_SRC-1:0] serviceable;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    serviceable              = '0;
    serviceable[N_SRC-1:0]   = pending_q & mask_i;
    lowest_id                = ID_W'(lowest_set(serviceable));

    clr_vec = '0;
    if (state_q == IRQ_ACTIVE && int_ack_i) clr_vec[id_q] = 1'b1;

    // A set in the same cycle as the clear wins, so the OR comes last.
    set_vec   = evt_i & mask_i;
    pending_d = (pending_q & ~clr_vec) | set_vec;

    overflow_d = overflow_q & ~ovf_clr_i;
    if (|(set_vec & edge_mode_i & pending_q & ~clr_vec)) overflow_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; every register here is a flop, none is a RAM.
    if (!reset) begin
      state_q    <= IRQ_IDLE;
      irq_out_q  <= 1'b0;
      id_q       <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      case (state_q)
        IRQ_IDLE: begin
          if (|serviceable) begin
            id_q      <= lowest_id;
            irq_out_q <= 1'b1;
            state_q   <= IRQ_ACTIVE;
          end
        end
        IRQ_ACTIVE: begin
          if (int_ack_i) begin
            irq_out_q <= 1'b0;
            state_q   <= IRQ_IDLE;
          end
        end
        default: state_q <= IRQ_IDLE;
      endcase
    end
  end

  assign irq_out_o  = irq_out_q;
  assign irq_id_o   = id_q;
  assign pending_o  = pending_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/irq_controller.sv
// Multi-output interrupt controller: shared input sync/edge stage feeding
// N_OUT independent channels, each with its own mask row and ack handshake.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter  int N_SRC = IRQ_N_SRC_DEFAULT,
  parameter  int N_OUT = 2,
  localparam int ID_W  = $clog2(N_SRC)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_SRC-1:0]       irq_in,
  input  logic [N_SRC-1:0]       edge_mode,
  input  logic [N_OUT*N_SRC-1:0] mask,
  input  logic [N_OUT-1:0]       int_ack,
  input  logic [N_OUT-1:0]       ovf_clr,
  output logic [N_OUT-1:0]       irq_out,
  output logic [N_OUT*ID_W-1:0]  irq_id,
  output logic [N_OUT*N_SRC-1:0] pending,
  output logic [N_OUT-1:0]       overflow
);

  logic [N_SRC-1:0] in_q, in_qq, evt;

  // Clearing in_qq on reset makes a source held high through reset look like
  // one fresh rising edge once reset is released.
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_q  <= '0;
      in_qq <= '0;
    end else begin
      in_q  <= irq_in;
      in_qq <= in_q;
    end
  end

  assign evt = (edge_mode & in_q & ~in_qq) | (~edge_mode & in_q);

  for (genvar j = 0; j < N_OUT; j++) begin : g_ch
    irq_channel #(.N_SRC(N_SRC)) u_ch (
      .clk         (clk),
      .reset       (reset),
      .evt_i       (evt),
      .edge_mode_i (edge_mode),
      .mask_i      (mask[j*N_SRC +: N_SRC]),
      .int_ack_i   (int_ack[j]),
      .ovf_clr_i   (ovf_clr[j]),
      .irq_out_o   (irq_out[j]),
      .irq_id_o    (irq_id[j*ID_W +: ID_W]),
      .pending_o   (pending[j*N_SRC +: N_SRC]),
      .overflow_o  (overflow[j])
    );
  end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a behavioural model.
module tb_irq_controller;

  localparam int NS = 8;
  localparam int NO = 2;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [NS-1:0]   irq_in;
  logic [NS-1:0]   edge_mode;
  logic [NO*NS-1:0] mask;
  logic [NO-1:0]   int_ack;
  logic [NO-1:0]   ovf_clr;
  logic [NO-1:0]   irq_out;
  logic [NO*IW-1:0] irq_id;
  logic [NO*NS-1:0] pending;
  logic [NO-1:0]   overflow;

  int total = 0;
  int bad   = 0;

  irq_controller #(.N_SRC(NS), .N_OUT(NO)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_in    (irq_in),
    .edge_mode (edge_mode),
    .mask      (mask),
    .int_ack   (int_ack),
    .ovf_clr   (ovf_clr),
    .irq_out   (irq_out),
    .irq_id    (irq_id),
    .pending   (pending),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the two-stage input history, per-output pending sets,
  // a busy flag with the serviced index, and the sticky lost-edge flag.
  bit m_q[NS], m_qq[NS];
  bit m_pend[NO][NS];
  bit m_ovf[NO];
  bit m_busy[NO];
  int m_id[NO];

  always @(posedge clk) begin
    bit evt[NS];
    bit old_pend[NS];
    int acked;
    bit found;
    if (!reset) begin
      for (int i = 0; i < NS; i++) begin
        m_q[i] = 0;
        m_qq[i] = 0;
      end
      for (int j = 0; j < NO; j++) begin
        for (int i = 0; i < NS; i++) m_pend[j][i] = 0;
        m_ovf[j] = 0;
        m_busy[j] = 0;
        m_id[j] = 0;
      end
    end else begin
      for (int i = 0; i < NS; i++)
        evt[i] = edge_mode[i] ? (m_q[i] && !m_qq[i]) : m_q[i];
      for (int j = 0; j < NO; j++) begin
        for (int i = 0; i < NS; i++) old_pend[i] = m_pend[j][i];
        acked = -1;
        if (m_busy[j] && int_ack[j]) acked = m_id[j];
        if (m_busy[j]) begin
          if (int_ack[j]) m_busy[j] = 0;
        end else begin
          found = 0;
          for (int i = 0; i < NS; i++) begin
            if (!found && old_pend[i] && mask[j*NS+i]) begin
              found = 1;
              m_busy[j] = 1;
              m_id[j] = i;
            end
          end
        end
        if (ovf_clr[j]) m_ovf[j] = 0;
        for (int i = 0; i < NS; i++) begin
          if (i == acked) m_pend[j][i] = 0;
          if (evt[i] && mask[j*NS+i]) begin
            if (edge_mode[i] && old_pend[i] && i != acked) m_ovf[j] = 1;
            m_pend[j][i] = 1;
          end
        end
      end
      for (int i = 0; i < NS; i++) begin
        m_qq[i] = m_q[i];
        m_q[i] = irq_in[i];
      end
    end
  end

  // Compare process: every output against the model on every falling edge.
  always @(negedge clk) begin
    logic [NO-1:0]    e_out, e_ovf;
    logic [NO*IW-1:0] e_id;
    logic [NO*NS-1:0] e_pend;
    for (int j = 0; j < NO; j++) begin
      e_out[j] = m_busy[j];
      e_ovf[j] = m_ovf[j];
      e_id[j*IW +: IW] = IW'(m_id[j]);
      for (int i = 0; i < NS; i++) e_pend[j*NS+i] = m_pend[j][i];
    end
    check("model_irq_out", 64'(irq_out), 64'(e_out));
    check("model_irq_id", 64'(irq_id), 64'(e_id));
    check("model_pending", 64'(pending), 64'(e_pend));
    check("model_overflow", 64'(overflow), 64'(e_ovf));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_out(input int j, input int budget);
    int n;
    n = 0;
    while (!irq_out[j] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_irq_out", 64'(irq_out[j]), 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    irq_in = '0;
    edge_mode = '0;
    mask = '0;
    int_ack = '0;
    ovf_clr = '0;
    tick(1);
    reset = 1'b1;
  endtask

  task automatic ack(input logic [NO-1:0] a);
    int_ack = a;
    tick(1);
    int_ack = '0;
  endtask

  initial begin
    reset = 1'b0;
    irq_in = 8'hFF;
    edge_mode = 8'hFF;
    mask = '0;
    int_ack = '0;
    ovf_clr = '0;

    // Source held high through reset: one edge event, request 3 edges after release.
    tick(3);
    check("rst_irq_out", 64'(irq_out), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_irq_id", 64'(irq_id), 64'd0);
    reset = 1'b1;
    mask = 16'h0001;
    tick(2);
    check("rel_out_at2", 64'(irq_out), 64'd0);
    check("rel_pend_at2", 64'(pending), 64'h0001);
    tick(1);
    check("rel_out_at3", 64'(irq_out), 64'b01);
    check("rel_id_at3", 64'(irq_id[2:0]), 64'd0);
    ack(2'b01);
    check("rel_ack_out", 64'(irq_out), 64'd0);
    check("rel_ack_pend", 64'(pending), 64'd0);
    tick(3);
    check("rel_single_evt", 64'(pending), 64'd0);

    // Priority among level sources, re-service while level holds.
    do_reset();
    mask = 16'h00FF;
    irq_in = 8'h24;
    wait_out(0, 10);
    check("prio_id2", 64'(irq_id[2:0]), 64'd2);
    ack(2'b01);
    check("prio_gap", 64'(irq_out), 64'd0);
    tick(1);
    check("prio_reserve_out", 64'(irq_out), 64'b01);
    check("prio_reserve_id", 64'(irq_id[2:0]), 64'd2);
    irq_in = 8'h20;
    tick(3);
    ack(2'b01);
    check("prio_gap2", 64'(irq_out), 64'd0);
    wait_out(0, 5);
    check("prio_id5", 64'(irq_id[2:0]), 64'd5);

    // Two edges on source 3 before ack: overflow, single service, clear.
    do_reset();
    edge_mode = 8'h08;
    mask = 16'h0800;
    irq_in = 8'h08; tick(1);
    irq_in = 8'h00; tick(1);
    irq_in = 8'h08; tick(1);
    irq_in = 8'h00; tick(3);
    check("ovf_pending", 64'(pending), 64'h0800);
    check("ovf_flag", 64'(overflow), 64'b10);
    check("ovf_out", 64'(irq_out), 64'b10);
    check("ovf_id", 64'(irq_id[5:3]), 64'd3);
    ack(2'b10);
    check("ovf_ack_out", 64'(irq_out), 64'd0);
    check("ovf_ack_pend", 64'(pending), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'b10);
    tick(3);
    check("ovf_single_service", 64'(irq_out), 64'd0);
    ovf_clr = 2'b10; tick(1); ovf_clr = '0;
    check("ovf_clr", 64'(overflow), 64'd0);

    // New edge on source 4 landing on the ack edge: set wins, no overflow.
    do_reset();
    edge_mode = 8'h10;
    mask = 16'h0010;
    irq_in = 8'h10; tick(1);
    irq_in = 8'h00;
    wait_out(0, 10);
    irq_in = 8'h10; tick(1);
    irq_in = 8'h00;
    ack(2'b01);
    check("coll_out_drop", 64'(irq_out), 64'd0);
    check("coll_pending", 64'(pending), 64'h0010);
    check("coll_overflow", 64'(overflow), 64'd0);
    tick(1);
    check("coll_reassert", 64'(irq_out), 64'b01);
    ack(2'b01);
    check("coll_cleared", 64'(pending), 64'd0);

    // Mask row isolation and masking during ACTIVE.
    do_reset();
    edge_mode = 8'h02;
    mask = 16'h0002;
    irq_in = 8'h02; tick(1);
    irq_in = 8'h00;
    wait_out(0, 10);
    check("mask_only_out0", 64'(irq_out), 64'b01);
    mask = '0;
    tick(3);
    check("mask_held_out", 64'(irq_out), 64'b01);
    check("mask_held_id", 64'(irq_id[2:0]), 64'd1);
    ack(2'b01);
    check("mask_ack", 64'(irq_out), 64'd0);
    irq_in = 8'h02; tick(1);
    irq_in = 8'h00; tick(5);
    check("mask_off_out", 64'(irq_out), 64'd0);
    check("mask_off_pend", 64'(pending), 64'd0);

    // Reset in the middle of an active service with overflow set.
    do_reset();
    edge_mode = 8'hFF;
    mask = 16'h0808;
    irq_in = 8'h08; tick(1);
    irq_in = 8'h00; tick(1);
    irq_in = 8'h08; tick(1);
    irq_in = 8'h00; tick(3);
    check("mid_out_pre", 64'(irq_out), 64'b11);
    check("mid_ovf_pre", 64'(overflow), 64'b11);
    reset = 1'b0; tick(1);
    check("mid_rst_out", 64'(irq_out), 64'd0);
    check("mid_rst_pend", 64'(pending), 64'd0);
    check("mid_rst_ovf", 64'(overflow), 64'd0);
    reset = 1'b1;

    // Randomized traffic checked by the model compare process.
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) edge_mode = 8'($urandom);
      if (c % 40 == 0) mask = 16'($urandom);
      irq_in  = irq_in ^ (8'($urandom) & 8'($urandom));
      int_ack = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      ovf_clr = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
      reset   = ($urandom_range(0, 499) != 0);
      tick(1);
    end
    reset = 1'b1;
    int_ack = '0;
    ovf_clr = '0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
